// File: rtl/cdt_timer.sv
// rtl/cdt_timer.sv - countdown timer with bus-mapped CTRL/LOAD/VALUE/STATUS registers
// Optional prescaler enabled by defining CDT_PRESCALER_EN.
module cdt_timer #(
    parameter int COUNT_W    = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cdt_sel,
    input  logic [3:0]  addr,
    input  logic [3:0]  cdt_wstrb,
    input  logic [31:0] cdt_di,
    output logic [31:0] cdt_do,
    output logic        cdt_ready,
    output logic        cdt_irq
);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t               state_q, state_d;
    logic                 sel_seen;
    logic                 en_q, en_d, reload_q, reload_d, irq_en_q, irq_en_d, exp_q, exp_d;
    logic [COUNT_W-1:0]   load_q, load_d, value_q, value_d;
    logic                 access, wr, ctrl_wr, load_wr, stat_wr, tick;
    logic [31:0]          ctrl_rd, rdata, wmerge;

    // One access per select assertion: only the first cycle sel is seen high counts.
    assign access  = cdt_sel && !sel_seen;
    assign wr      = access && (|cdt_wstrb);
    assign ctrl_wr = wr && (addr == 4'h0);
    assign load_wr = wr && (addr == 4'h4);
    assign stat_wr = wr && (addr == 4'hC);

`ifdef CDT_PRESCALER_EN
    logic [PRESCALE_W-1:0] psc_q, psc_d, pcnt_q, pcnt_d;
    assign tick = (state_q == RUN) && (pcnt_q == psc_q);
`else
    assign tick = (state_q == RUN);
`endif

    always_comb begin
        ctrl_rd    = '0;
        ctrl_rd[0] = en_q;
        ctrl_rd[1] = reload_q;
        ctrl_rd[2] = irq_en_q;
`ifdef CDT_PRESCALER_EN
        ctrl_rd[8 +: PRESCALE_W] = psc_q;
`else
        ctrl_rd[8 +: PRESCALE_W] = '0;
`endif
    end

    always_comb begin
        rdata = '0;
        case (addr)
            4'h0: rdata = ctrl_rd;
            4'h4: rdata[COUNT_W-1:0] = load_q;
            4'h8: rdata[COUNT_W-1:0] = value_q;
            4'hC: begin
                rdata[0] = exp_q;
                rdata[1] = (state_q == RUN);
            end
            default: rdata = '0;
        endcase
    end

    // Unstrobed bytes keep the register's current contents.
    always_comb begin
        wmerge = '0;
        for (int b = 0; b < 4; b++) begin
            wmerge[8*b +: 8] = cdt_wstrb[b] ? cdt_di[8*b +: 8] : rdata[8*b +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        reload_d = reload_q;
        irq_en_d = irq_en_q;
        exp_d    = exp_q;
        load_d   = load_q;
        value_d  = value_q;
`ifdef CDT_PRESCALER_EN
        psc_d    = psc_q;
        pcnt_d   = pcnt_q;
`endif
        if (ctrl_wr) begin
            en_d     = wmerge[0];
            reload_d = wmerge[1];
            irq_en_d = wmerge[2];
`ifdef CDT_PRESCALER_EN
            psc_d    = wmerge[8 +: PRESCALE_W];
`endif
        end
        if (load_wr) begin
            load_d = wmerge[COUNT_W-1:0];
        end
        if (stat_wr && cdt_wstrb[0] && cdt_di[0]) begin
            exp_d = 1'b0;
        end
        case (state_q)
            IDLE, EXPIRED: begin
                if (ctrl_wr && wmerge[0]) begin
                    state_d = RUN;
                    value_d = load_q;
`ifdef CDT_PRESCALER_EN
                    pcnt_d  = '0;
`endif
                end
            end
            RUN: begin
                if (ctrl_wr && !wmerge[0]) begin
                    state_d = IDLE;
                end else begin
`ifdef CDT_PRESCALER_EN
                    pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
`endif
                    if (tick) begin
                        if (value_q != '0) begin
                            value_d = value_q - COUNT_W'(1);
                        end else begin
                            // Expiry sets EXP after any same-edge W1C, so set wins.
                            exp_d = 1'b1;
                            if (reload_q) begin
                                value_d = load_q;
                            end else begin
                                state_d = EXPIRED;
                                en_d    = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_seen  <= 1'b0;
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            exp_q     <= 1'b0;
            load_q    <= '0;
            value_q   <= '0;
            cdt_do    <= '0;
            cdt_ready <= 1'b0;
            cdt_irq   <= 1'b0;
`ifdef CDT_PRESCALER_EN
            psc_q     <= '0;
            pcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_seen  <= cdt_sel;
            en_q      <= en_d;
            reload_q  <= reload_d;
            irq_en_q  <= irq_en_d;
            exp_q     <= exp_d;
            load_q    <= load_d;
            value_q   <= value_d;
            cdt_ready <= access;
            cdt_do    <= (access && !(|cdt_wstrb)) ? rdata : '0;
            cdt_irq   <= exp_q & irq_en_q;
`ifdef CDT_PRESCALER_EN
            psc_q     <= psc_d;
            pcnt_q    <= pcnt_d;
`endif
        end
    end

endmodule
